// File: rtl/ram_access_ctrl_pkg.sv
// Shared widths, FSM state type and helpers for the 74189-based byte RAM controller.
package ram_access_ctrl_pkg;

  localparam int unsigned RAM_ADDR_W = 4;
  localparam int unsigned RAM_NIB_W  = 4;
  localparam int unsigned RAM_DATA_W = 2 * RAM_NIB_W;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWrite,
    StHold,
    StRead,
    StVerify,
    StResp
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ram_delay_cnt.sv
// Loadable saturating down-counter used to time each phase of a RAM access.
module ram_delay_cnt #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ram_access_ctrl.sv
// Byte-wide RAM initiator for two 74189 16x4 chips (chip0 = low nibble, chip1 = high nibble).
// Build option: define RAM_WRITE_VERIFY_EN to read back and compare every write.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned WE_CYC    = 1,
  parameter int unsigned RD_CYC    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [RAM_ADDR_W-1:0] req_addr,
  input  logic [RAM_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [RAM_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_cs_n,
  output logic                  ram_we_n,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic [RAM_DATA_W-1:0] ram_d,
  input  logic [RAM_DATA_W-1:0] ram_q
);

  localparam int unsigned CntW = $clog2(max3(SETUP_CYC, WE_CYC, RD_CYC) + 1);
  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] WeLd    = CntW'(WE_CYC - 1);
  localparam logic [CntW-1:0] RdLd    = CntW'(RD_CYC - 1);

  if (SETUP_CYC == 0 || WE_CYC == 0 || RD_CYC == 0) begin : g_bad_param
    $error("ram_access_ctrl: SETUP_CYC, WE_CYC and RD_CYC must all be >= 1");
  end

  state_e          state_q;
  logic            op_write_q;
  logic            accept;
  logic            cnt_load;
  logic            cnt_dec;
  logic            cnt_zero;
  logic [CntW-1:0] cnt_val;

  assign accept = req_valid && req_ready;

  ram_delay_cnt #(
    .W(CntW)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Counter holds (remaining cycles - 1) of the current phase; zero marks its last cycle.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_load = 1'b1;
          cnt_val  = SetupLd;
        end
      end
      StSetup: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = op_write_q ? WeLd : RdLd;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StWrite, StRead, StVerify: cnt_dec = 1'b1;
`ifdef RAM_WRITE_VERIFY_EN
      StHold: begin
        cnt_load = 1'b1;
        cnt_val  = RdLd;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_write_q <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
`ifdef RAM_WRITE_VERIFY_EN
      rsp_err    <= 1'b0;
`endif
      ram_cs_n   <= 1'b1;
      ram_we_n   <= 1'b1;
      ram_a      <= '0;
      ram_d      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q    <= StSetup;
            req_ready  <= 1'b0;
            ram_cs_n   <= 1'b0;
            ram_a      <= req_addr;
            ram_d      <= req_wdata;
            op_write_q <= req_write;
          end else begin
            req_ready <= 1'b1;
          end
        end
        StSetup: begin
          if (cnt_zero) begin
            if (op_write_q) begin
              state_q  <= StWrite;
              ram_we_n <= 1'b0;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StWrite: begin
          if (cnt_zero) begin
            state_q  <= StHold;
            ram_we_n <= 1'b1;
          end
        end
        StHold: begin
`ifdef RAM_WRITE_VERIFY_EN
          state_q   <= StVerify;
`else
          state_q   <= StResp;
          rsp_valid <= 1'b1;
          ram_cs_n  <= 1'b1;
`endif
        end
        StRead: begin
          if (cnt_zero) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= ram_q;
`ifdef RAM_WRITE_VERIFY_EN
            rsp_err   <= 1'b0;
`endif
            ram_cs_n  <= 1'b1;
          end
        end
        StVerify: begin
`ifdef RAM_WRITE_VERIFY_EN
          if (cnt_zero) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= ram_q;
            rsp_err   <= (ram_q != ram_d);
            ram_cs_n  <= 1'b1;
          end
`else
          state_q <= StIdle;
`endif
        end
        StResp: begin
          state_q   <= StIdle;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef RAM_WRITE_VERIFY_EN
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench: two controllers (default and slow timing) on behavioural 74189 pairs.
module tb_ram_access_ctrl;

`ifdef RAM_WRITE_VERIFY_EN
  localparam bit Verify = 1'b1;
`else
  localparam bit Verify = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_write;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       valid_a, valid_b, ready_a, ready_b, rspv_a, rspv_b, err_a, err_b;
  logic       cs_a, cs_b, we_a, we_b;
  logic [7:0] rdata_a, rdata_b, d_a, d_b, q_a, q_b;
  logic [3:0] ra_a, ra_b;
  logic [3:0] c0_a [16];
  logic [3:0] c1_a [16];
  logic [3:0] c0_b [16];
  logic [3:0] c1_b [16];
  bit         stuck;

  logic [7:0] mem [2][16];
  bit         known [2][16];
  logic [7:0] last_rd [2];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  ram_access_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv_a), .rsp_rdata(rdata_a),
    .rsp_err(err_a), .ram_cs_n(cs_a), .ram_we_n(we_a), .ram_a(ra_a), .ram_d(d_a), .ram_q(q_a)
  );

  ram_access_ctrl #(.SETUP_CYC(3), .WE_CYC(2), .RD_CYC(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(ready_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv_b), .rsp_rdata(rdata_b),
    .rsp_err(err_b), .ram_cs_n(cs_b), .ram_we_n(we_b), .ram_a(ra_b), .ram_d(d_b), .ram_q(q_b)
  );

  // 74189 pairs: write while CS and WE are low, read combinationally while selected.
  always @(posedge clk) begin
    if (!cs_a && !we_a) begin
      c0_a[ra_a] <= d_a[3:0];
      c1_a[ra_a] <= d_a[7:4];
    end
    if (!cs_b && !we_b) begin
      c0_b[ra_b] <= d_b[3:0];
      c1_b[ra_b] <= d_b[7:4];
    end
  end

  assign q_a = (!cs_a && we_a) ? ({c1_a[ra_a], c0_a[ra_a]} & (stuck ? 8'hFE : 8'hFF)) : 8'h00;
  assign q_b = (!cs_b && we_b) ? {c1_b[ra_b], c0_b[ra_b]} : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle 1 is the cycle right after the accepting edge; latency is the cycle rsp_valid is high.
  task automatic run_req(input bit sel, input bit wr, input logic [3:0] a, input logic [7:0] d,
                         input string tag);
    int s_c, w_c, r_c, lat_exp, cyc, pre, we_cnt, bad_rdy, bad_bus;
    bit seen_we;
    logic [7:0] exp_rd;
    logic exp_err;
    s_c = sel ? 3 : 1;
    w_c = sel ? 2 : 1;
    r_c = sel ? 2 : 1;
    lat_exp = wr ? (s_c + w_c + 2 + (Verify ? r_c : 0)) : (s_c + r_c + 1);
    if (wr) begin
      exp_rd  = Verify ? (d & (stuck ? 8'hFE : 8'hFF)) : last_rd[sel];
      exp_err = Verify && (exp_rd != d);
    end else begin
      exp_rd  = mem[sel][a];
      exp_err = 1'b0;
    end
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    if (sel) valid_b = 1'b1;
    else valid_a = 1'b1;
    cyc = 0;
    while (!(sel ? ready_b : ready_a) && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    @(posedge clk);
    #1;
    cyc = 1; pre = 0; we_cnt = 0; bad_rdy = 0; bad_bus = 0; seen_we = 1'b0;
    while (cyc <= 40) begin
      if (sel ? rspv_b : rspv_a) break;
      if (sel ? ready_b : ready_a) bad_rdy++;
      if ((sel ? ra_b : ra_a) !== a || (sel ? d_b : d_a) !== d) bad_bus++;
      if (!(sel ? we_b : we_a)) begin
        seen_we = 1'b1;
        we_cnt++;
        if (sel ? cs_b : cs_a) bad_bus++;
      end else if (!seen_we && !(sel ? cs_b : cs_a)) begin
        pre++;
      end
      // Request fields wander while busy; only the accepted values may reach the RAM.
      req_addr  = 4'($urandom);
      req_wdata = 8'($urandom);
      req_write = 1'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
    if (sel) valid_b = 1'b0;
    else valid_a = 1'b0;
    chk({tag, " latency"}, 32'(cyc), 32'(lat_exp));
    chk({tag, " rdata"}, 32'(sel ? rdata_b : rdata_a), 32'(exp_rd));
    chk({tag, " err"}, 32'(sel ? err_b : err_a), 32'(exp_err));
    chk({tag, " cs-low pre-WE"}, 32'(pre), 32'(wr ? s_c : s_c + r_c));
    chk({tag, " WE width"}, 32'(we_cnt), 32'(wr ? w_c : 0));
    chk({tag, " busy ready"}, 32'(bad_rdy), 32'(0));
    chk({tag, " bus stability"}, 32'(bad_bus), 32'(0));
    chk({tag, " resp cs_n"}, 32'(sel ? cs_b : cs_a), 32'(1));
    chk({tag, " resp ready"}, 32'(sel ? ready_b : ready_a), 32'(0));
    @(posedge clk);
    #1;
    chk({tag, " rsp one-cycle"}, 32'(sel ? rspv_b : rspv_a), 32'(0));
    chk({tag, " rdata hold"}, 32'(sel ? rdata_b : rdata_a), 32'(exp_rd));
    chk({tag, " idle ready"}, 32'(sel ? ready_b : ready_a), 32'(1));
    if (wr) begin
      mem[sel][a]   = d;
      known[sel][a] = 1'b1;
    end
    last_rd[sel] = exp_rd;
  endtask

  initial begin
    int cyc;
    bit s, w;
    logic [3:0] ra;
    stuck = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    req_write = 1'b0;
    req_addr = 4'h0;
    req_wdata = 8'h00;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("reset cs_n", 32'(cs_a), 32'(1));
    chk("reset we_n", 32'(we_a), 32'(1));
    chk("reset ram_a", 32'(ra_a), 32'(0));
    chk("reset ram_d", 32'(d_a), 32'(0));
    chk("reset rsp_valid", 32'(rspv_a), 32'(0));
    chk("reset rsp_rdata", 32'(rdata_a), 32'(0));
    chk("reset rsp_err", 32'(err_a), 32'(0));
    chk("reset req_ready", 32'(ready_a), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready before first edge", 32'(ready_a), 32'(0));
    @(posedge clk);
    #1;
    chk("ready after release a", 32'(ready_a), 32'(1));
    chk("ready after release b", 32'(ready_b), 32'(1));

    run_req(0, 1'b1, 4'h3, 8'hA5, "wr 3");
    run_req(0, 1'b0, 4'h3, 8'h11, "rd 3");
    run_req(0, 1'b1, 4'h0, 8'h00, "wr 0");
    run_req(0, 1'b1, 4'hF, 8'hFF, "wr F");
    run_req(0, 1'b0, 4'h0, 8'h5C, "rd 0");
    run_req(0, 1'b0, 4'hF, 8'h3E, "rd F");
    chk("chip0[F]", 32'(c0_a[15]), 32'(4'hF));
    chk("chip1[0]", 32'(c1_a[0]), 32'(4'h0));
    chk("chip0[3]", 32'(c0_a[3]), 32'(4'h5));
    chk("chip1[3]", 32'(c1_a[3]), 32'(4'hA));

    // Abort a write mid-pulse with an asynchronous reset.
    req_write = 1'b1;
    req_addr  = 4'h7;
    req_wdata = 8'h3C;
    valid_a   = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    cyc = 0;
    while (we_a && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("mid-write WE low", 32'(we_a), 32'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort we_n", 32'(we_a), 32'(1));
    chk("abort cs_n", 32'(cs_a), 32'(1));
    chk("abort rsp_valid", 32'(rspv_a), 32'(0));
    chk("abort req_ready", 32'(ready_a), 32'(0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("abort ready held low", 32'(ready_a), 32'(0));
    @(posedge clk);
    #1;
    chk("abort ready one edge", 32'(ready_a), 32'(1));
    known[0][7] = 1'b0;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;

    run_req(1, 1'b1, 4'h9, 8'h5A, "slow wr 9");
    run_req(1, 1'b0, 4'h9, 8'h77, "slow rd 9");

    stuck = 1'b1;
    run_req(0, 1'b1, 4'h5, 8'h01, "stuck wr 01");
    run_req(0, 1'b1, 4'h5, 8'h02, "stuck wr 02");
    stuck = 1'b0;

    for (int i = 0; i < 16; i++) begin
      s  = i[0];
      ra = 4'($urandom);
      w  = (($urandom % 2) == 1) || !known[s][ra];
      run_req(s, w, ra, 8'($urandom), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
